// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP accumulation array: FSM encoding and width helpers.
package sfp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Default widths of the array; modules take the real values as parameters.
  localparam int psum_bw_dflt = 16;
  localparam int cnt_w_dflt   = 4;

  // Accumulator width at the default widths: wide enough for the largest job.
  localparam int acc_bw = psum_bw_dflt + cnt_w_dflt;

  // Accumulator width for a given lane width and length-counter width.
  function automatic int acc_width(input int p_bw, input int c_w);
    return p_bw + c_w;
  endfunction

endpackage

// File: rtl/sfp_lane.sv
// One column of the SFP array: sign-extending accumulator, saturation to the
// lane width, optional ReLU and the registered result.
module sfp_lane
  import sfp_pkg::*;
#(
  parameter int psum_bw = psum_bw_dflt,
  parameter int cnt_w   = cnt_w_dflt
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               acc_en_i,
  input  logic               load_i,
  input  logic               relu_i,
  input  logic [psum_bw-1:0] in_i,
  output logic [psum_bw-1:0] out_o
);

  localparam int acc_w = acc_width(psum_bw, cnt_w);

  // Accumulator bounds that still fit in a signed psum_bw value.
  localparam logic signed [acc_w-1:0] sat_hi = {{(cnt_w + 1){1'b0}}, {(psum_bw - 1){1'b1}}};
  localparam logic signed [acc_w-1:0] sat_lo = {{(cnt_w + 1){1'b1}}, {(psum_bw - 1){1'b0}}};

  logic signed [acc_w-1:0]   acc_q;
  logic signed [acc_w-1:0]   acc_d;
  logic signed [acc_w-1:0]   sum;
  logic        [psum_bw-1:0] sat;
  logic        [psum_bw-1:0] res;
  logic        [psum_bw-1:0] out_q;
  logic        [psum_bw-1:0] out_d;

  // Running sum including the current beat, then clamp and ReLU of that sum so
  // the final beat's contribution lands in the output register on the same edge.
  always_comb begin
    sum = acc_q + {{cnt_w{in_i[psum_bw-1]}}, in_i};
    if (sum > sat_hi) begin
      sat = {1'b0, {(psum_bw - 1){1'b1}}};
    end else if (sum < sat_lo) begin
      sat = {1'b1, {(psum_bw - 1){1'b0}}};
    end else begin
      sat = sum[psum_bw-1:0];
    end
    if (relu_i && sat[psum_bw-1]) begin
      res = '0;
    end else begin
      res = sat;
    end
  end

  // Next-state selection for accumulator and output register.
  always_comb begin
    if (clear_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = sum;
    end else begin
      acc_d = acc_q;
    end
    if (load_i) begin
      out_d = res;
    end else begin
      out_d = out_q;
    end
  end

  // Lane state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/sfp_array.sv
// SFP array top: shared job FSM and beat counter driving col independent lanes
// that accumulate cfg_acc_len psum vectors and emit one saturated result.
module sfp_array
  import sfp_pkg::*;
#(
  parameter int psum_bw = psum_bw_dflt,
  parameter int col     = 8,
  parameter int cnt_w   = cnt_w_dflt
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [cnt_w-1:0]       cfg_acc_len,
  input  logic                   cfg_relu,
  input  logic                   i_valid,
  input  logic [psum_bw*col-1:0] in,
  output logic                   i_ready,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   busy
);

  localparam logic [cnt_w-1:0] cnt_one = {{(cnt_w - 1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [cnt_w-1:0] cnt_q;
  logic [cnt_w-1:0] len_q;
  logic             relu_q;
  logic             i_ready_q;
  logic             o_valid_q;
  logic             busy_q;

  logic             accept;
  logic             last_beat;
  logic             lane_clear;
  logic             lane_load;

  // Handshake decode shared by the FSM and every lane.
  always_comb begin
    accept     = i_valid && i_ready_q;
    last_beat  = (cnt_q == (len_q - cnt_one));
    lane_clear = (state_q == ST_IDLE) && cfg_start;
    lane_load  = accept && last_beat;
  end

  // Job FSM: latch config on start, count accepted beats, hold result until taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      relu_q    <= 1'b0;
      i_ready_q <= 1'b0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            len_q     <= (cfg_acc_len == '0) ? cnt_one : cfg_acc_len;
            relu_q    <= cfg_relu;
            cnt_q     <= '0;
            state_q   <= ST_ACC;
            i_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_ACC: begin
          if (accept) begin
            if (last_beat) begin
              cnt_q     <= '0;
              state_q   <= ST_OUT;
              i_ready_q <= 1'b0;
              o_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + cnt_one;
            end
          end
        end
        ST_OUT: begin
          if (o_ready) begin
            state_q   <= ST_IDLE;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          i_ready_q <= 1'b0;
          o_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_lane
    sfp_lane #(
      .psum_bw (psum_bw),
      .cnt_w   (cnt_w)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (lane_clear),
      .acc_en_i (accept),
      .load_i   (lane_load),
      .relu_i   (relu_q),
      .in_i     (in[psum_bw*(g+1)-1 -: psum_bw]),
      .out_o    (out[psum_bw*(g+1)-1 -: psum_bw])
    );
  end

  assign i_ready = i_ready_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;

endmodule

// File: doc/sfp_array.md
SFP_ARRAY -- requirements
Module: sfp_array

Interface
REQ-001 The block SHALL have parameter psum_bw, default 16, meaning signed input and output lane width.
REQ-002 The block SHALL have parameter col, default 8, meaning the number of independent lanes (columns).
REQ-003 The block SHALL have parameter cnt_w, default 4, meaning the accumulation-length counter width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-low reset sampled on the clk rising edge.
REQ-006 The block SHALL have port cfg_start, input, 1 bit, a one-cycle pulse that starts an accumulation job.
REQ-007 The block SHALL have port cfg_acc_len, input, cnt_w bits, the number of psum vectors to accumulate (0 is treated as 1).
REQ-008 The block SHALL have port cfg_relu, input, 1 bit, which enables ReLU on the result.
REQ-009 The block SHALL have port i_valid, input, 1 bit, marking the input psum vector valid.
REQ-010 The block SHALL have port in, input, psum_bw*col bits, carrying lane i in bits [psum_bw*(i+1)-1:psum_bw*i], signed.
REQ-011 The block SHALL have port i_ready, output, 1 bit, indicating the block accepts input.
REQ-012 The block SHALL have port out, output, psum_bw*col bits, carrying the result vector with the same lane packing as in.
REQ-013 The block SHALL have port o_valid, output, 1 bit, marking the result valid.
REQ-014 The block SHALL have port o_ready, input, 1 bit, indicating the consumer accepts the result.
REQ-015 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACC and OUT.
REQ-017 In IDLE, cfg_start SHALL latch cfg_acc_len and cfg_relu, clear all accumulators and the counter, and move to ACC on the next cycle; cfg_start in ACC or OUT SHALL be ignored.
REQ-018 In ACC, i_ready SHALL be 1; in IDLE and OUT it SHALL be 0, and an input beat is accepted only when i_valid&&i_ready.
REQ-019 Each accepted beat SHALL add every sign-extended lane to that lane's accumulator, which is psum_bw+cnt_w bits wide so that it never overflows.
REQ-020 On acceptance of beat number len (the latched length), the FSM SHALL enter OUT, with o_valid=1 on the following cycle and out registered.
REQ-021 Each out lane SHALL be the accumulator saturated to signed psum_bw bits (0x7FFF / 0x8000 at 16 bits), then, if ReLU is latched, negative values SHALL be forced to 0.
REQ-022 In OUT, out and o_valid SHALL hold stable until o_ready=1; on the cycle o_valid&&o_ready, the FSM SHALL return to IDLE with o_valid=0 on the next cycle.
REQ-023 Input beats with i_valid=1 outside ACC SHALL have no effect.
REQ-024 A new cfg_start SHALL be accepted in the cycle immediately after the OUT handshake, once the FSM is back in IDLE.

Reset
REQ-025 While reset=0 at a clk edge, the block SHALL set state IDLE, all accumulators and the counter to 0, out to 0, o_valid, i_ready and busy to 0, and the latched cfg to 0.
REQ-026 Reset asserted mid-ACC or mid-OUT SHALL abort the job with no output produced.

Structure
REQ-027 Package sfp_pkg SHALL hold the state encoding (IDLE=0, ACC=1, OUT=2) and the localparam acc_bw = psum_bw + cnt_w.
REQ-028 Sub-module sfp_lane SHALL be instantiated col times (accumulate, saturate, ReLU, output register), with the FSM and counter shared in sfp_array.

Verification
REQ-029 Reset check: hold reset=0 for 2 cycles -> out=0, o_valid=0, i_ready=0, busy=0.
REQ-030 Accumulation: len=3, lane0 inputs 100, -50, 25 -> lane0 out=75 with o_valid one cycle after the third accept.
REQ-031 ReLU: len=2, lane1 inputs -10, -20: with relu=1 -> 0; with relu=0 -> -30 (0xFFE2).
REQ-032 Saturation: len=4, all lanes 0x7000 x4 -> 0x7FFF; all lanes 0x9000 x4 -> 0x8000.
REQ-033 Backpressure: hold o_ready=0 for 5 cycles in OUT while driving i_valid=1 -> out stable, i_ready=0, the extra inputs ignored, and the next job's result is unaffected.
REQ-034 Reset mid-ACC: after 2 of 4 beats, pulse reset=0 -> IDLE, o_valid never asserts; a new len=1 job with input 5 -> out=5.
